serial_to_parallel: RTL
=======================

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter: WIDTH, default 8, sets the parallel word width; legal range 2..16.
REQ-002 Parameter: MSB_FIRST, default 1; 1 means the first serial bit lands in Q[WIDTH-1], 0 means it lands in Q[0].
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: D  input  1  serial data bit, normally driven by the upstream D flip-flop Q1 output.
REQ-006 Port: en  input  1  bit strobe; D is sampled only on edges where en=1.
REQ-007 Port: clear  input  1  synchronous flush of the partial word.
REQ-008 Port: ready  input  1  downstream accepts the held word.
REQ-009 Port: Q  output  WIDTH  assembled parallel word.
REQ-010 Port: valid  output  1  Q holds an unconsumed word.
REQ-011 Port: bit_cnt  output  $clog2(WIDTH)+1  bits collected in the current partial word.
REQ-012 Port: overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-013 Block SHALL contain a shift register (SR), a bit counter, an output register (Q), and a 2-state output FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-014 On an edge with en=1 and clear=0, the block SHALL shift D into SR: MSB_FIRST=1 -> SR={SR[WIDTH-2:0],D}; MSB_FIRST=0 -> SR={D,SR[WIDTH-1:1]}.
REQ-015 bit_cnt SHALL increment by 1 per sampled bit and SHALL never hold WIDTH; when bit_cnt=WIDTH-1 and en=1, the word completes and bit_cnt wraps to 0 on that same edge.
REQ-016 On word completion, the candidate word SHALL be the post-shift SR value, including the current D.
REQ-017 In EMPTY, a completed word SHALL load into Q on the completing edge, and the FSM SHALL move to FULL; valid=1 from the following cycle (1-cycle latency from the last bit).
REQ-018 In FULL with ready=1 and no completion, the FSM SHALL move to EMPTY; Q SHALL hold its value.
REQ-019 In FULL with ready=1 and completion on the same edge, Q SHALL load the new word and the FSM SHALL stay FULL (back-to-back, no bubble).
REQ-020 In FULL with ready=0 and completion, Q SHALL keep the old word, the new word SHALL be discarded, and overrun SHALL be 1 for exactly the next cycle.
REQ-021 Collection into SR SHALL continue regardless of FSM state; ready SHALL NOT stall sampling.
REQ-022 clear=1 SHALL zero SR and bit_cnt on that edge and take priority over en; clear SHALL NOT affect Q, valid, or the FSM.
REQ-023 ready while EMPTY SHALL be ignored.
REQ-024 overrun SHALL be 0 in every cycle not covered by REQ-020.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clk, force SR=0, bit_cnt=0, Q=0, valid=0 (EMPTY), and overrun=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release, collection restarts at bit_cnt=0.
REQ-027 After reset deasserts, the first rising edge SHALL be a normal operating edge.

Verification (WIDTH=8)
REQ-028 MSB_FIRST=1, en=1, serial 1,0,1,1,0,0,1,0 over 8 cycles -> Q=8'hB2 and valid=1 one cycle after the 8th bit; bit_cnt=0.
REQ-029 MSB_FIRST=0, same stream -> Q=8'h4D.
REQ-030 Word 8'hA5 is held with ready=0, then 8'h3C completes -> Q stays 8'hA5, overrun pulses 1 cycle; then ready=1 -> valid=0.
REQ-031 ready=1 on the same edge that 8'h3C completes while 8'hA5 is held -> Q=8'h3C, valid stays 1, no overrun.
REQ-032 After 5 bits, clear=1 with en=1 -> bit_cnt=0; the next 8 bits 8'hFF -> Q=8'hFF.
REQ-033 After 3 bits, reset pulsed low between clock edges -> all outputs are 0 immediately; 8 new bits 8'h01 -> Q=8'h01.

Source files
------------

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: collects WIDTH serial bits into a word and
// holds it in an output register under a valid/ready handshake with overrun flag.
module serial_to_parallel #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   D,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   ready,
  output logic [WIDTH-1:0]       Q,
  output logic                   valid,
  output logic [$clog2(WIDTH):0] bit_cnt,
  output logic                   overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overrun;
  logic             w_sample;
  logic             w_complete;
  logic             w_load_q;
  logic             w_overrun_next;

  // Post-shift SR value; also the candidate word on completion
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_sr_shift = {r_sr[WIDTH-2:0], D};
    end else begin : g_lsb_first
      assign w_sr_shift = {D, r_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_sample   = en & ~clear;
  assign w_complete = w_sample && (r_cnt == CNT_W'(WIDTH - 1));

  // Collection path runs independently of the output handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_sr  <= w_sr_shift;
      r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_load_q       = 1'b0;
    w_overrun_next = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_complete) begin
          w_load_q     = 1'b1;
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (w_complete) begin
          if (ready) begin
            w_load_q = 1'b1;
          end else begin
            w_overrun_next = 1'b1;
          end
        end else if (ready) begin
          w_state_next = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load_q) begin
        r_q <= w_sr_shift;
      end
      r_overrun <= w_overrun_next;
    end
  end

  assign Q       = r_q;
  assign valid   = (r_state == S_FULL);
  assign bit_cnt = r_cnt;
  assign overrun = r_overrun;

endmodule
